// File: rtl/regfile_wb_queue.sv
// In-order write-back queue for the 16x32 register file with read-after-write forwarding.
// Optional macro REGFILE_WB_ZERO_REG_EN hardwires register 0 to zero (writes to it are dropped).
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_idx,
  input  logic [DW-1:0]            in_data,
  input  logic                     flush,
  output logic                     wr_en,
  output logic [AW-1:0]            wr_idx,
  output logic [DW-1:0]            wr_data,
  input  logic                     wr_ack,
  input  logic [AW-1:0]            rd_idx,
  output logic                     fwd_hit,
  output logic [DW-1:0]            fwd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_FLUSH = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   head_q, head_d;
  logic [PW-1:0]   tail_q, tail_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   idx_q  [DEPTH];
  logic [AW-1:0]   idx_d  [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [DW-1:0]   data_d [DEPTH];

  logic            push;
  logic            store;
  logic            pop;
  logic            hit;
  logic [DW-1:0]   hit_data;
  logic [PW-1:0]   scan_ptr;

  assign in_ready = (count_q < CW'(DEPTH)) && !flush && (state_q == ST_RUN);
  assign wr_en    = (count_q != {CW{1'b0}});
  assign push     = in_valid && in_ready;
  assign pop      = wr_en && wr_ack;

  // A request to register 0 completes its handshake but is never stored when the zero register is hardwired.
  always_comb begin
`ifdef REGFILE_WB_ZERO_REG_EN
    store = push && (in_idx != {AW{1'b0}});
`else
    store = push;
`endif
  end

  // Next-state for FSM, pointers, occupancy and storage; flush discards everything, including an ack.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    idx_d   = idx_q;
    data_d  = data_q;
    case (state_q)
      ST_RUN:   state_d = flush ? ST_FLUSH : ST_RUN;
      ST_FLUSH: state_d = flush ? ST_FLUSH : ST_RUN;
      default:  state_d = ST_RUN;
    endcase
    if (flush) begin
      head_d  = {PW{1'b0}};
      tail_d  = {PW{1'b0}};
      count_d = {CW{1'b0}};
    end else begin
      if (store) begin
        idx_d[tail_q]  = in_idx;
        data_d[tail_q] = in_data;
        tail_d         = tail_q + PW'(1);
      end else begin
        tail_d = tail_q;
      end
      if (pop) begin
        head_d = head_q + PW'(1);
      end else begin
        head_d = head_q;
      end
      case ({store, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      head_q  <= {PW{1'b0}};
      tail_q  <= {PW{1'b0}};
      count_q <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; contents are only ever observed through occupied slots, so no reset is needed.
  always_ff @(posedge clk) begin
    idx_q  <= idx_d;
    data_q <= data_d;
  end

  // Scan oldest to youngest so the last match (closest to tail) wins.
  always_comb begin
    hit      = 1'b0;
    hit_data = {DW{1'b0}};
    scan_ptr = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      scan_ptr = head_q + PW'(i);
      if ((CW'(i) < count_q) && (idx_q[scan_ptr] == rd_idx)) begin
        hit      = 1'b1;
        hit_data = data_q[scan_ptr];
      end else begin
        hit      = hit;
        hit_data = hit_data;
      end
    end
`ifdef REGFILE_WB_ZERO_REG_EN
    if (rd_idx == {AW{1'b0}}) begin
      hit      = 1'b0;
      hit_data = {DW{1'b0}};
    end else begin
      hit      = hit;
      hit_data = hit_data;
    end
`endif
  end

  // Show-ahead head presentation, forced to zero while empty.
  always_comb begin
    if (wr_en) begin
      wr_idx  = idx_q[head_q];
      wr_data = data_q[head_q];
    end else begin
      wr_idx  = {AW{1'b0}};
      wr_data = {DW{1'b0}};
    end
  end

  assign fwd_hit  = hit;
  assign fwd_data = hit_data;
  assign count    = count_q;

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed self-checking bench for regfile_wb_queue; inputs change on negedge, DUT commits on posedge.
module tb_regfile_wb_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  in_idx = 4'd0;
  logic [31:0] in_data = 32'd0;
  logic        flush = 1'b0;
  logic        wr_en;
  logic [3:0]  wr_idx;
  logic [31:0] wr_data;
  logic        wr_ack = 1'b0;
  logic [3:0]  rd_idx = 4'd0;
  logic        fwd_hit;
  logic [31:0] fwd_data;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_wb_queue #(.DEPTH(4), .DW(32), .AW(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_idx(in_idx), .in_data(in_data), .flush(flush), .wr_en(wr_en),
    .wr_idx(wr_idx), .wr_data(wr_data), .wr_ack(wr_ack), .rd_idx(rd_idx),
    .fwd_hit(fwd_hit), .fwd_data(fwd_data), .count(count)
  );

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; in_valid = 1'b0; wr_ack = 1'b0; flush = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    checks++; if (wr_idx !== 4'd0 || wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_bus got %h/%h exp 0/0", wr_idx, wr_data); end
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin errors++; $display("FAIL reset_fwd got %b/%h exp 0/0", fwd_hit, fwd_data); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    @(negedge clk); in_valid = 1'b1; in_idx = 4'd5; in_data = 32'hDEAD_BEEF; wr_ack = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %b exp 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (wr_en !== 1'b1 || wr_idx !== 4'd5 || wr_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_head got %b/%h/%h exp 1/5/deadbeef", wr_en, wr_idx, wr_data); end
    checks++; if (count !== 3'd1) begin errors++; $display("FAIL single_count1 got %0d exp 1", count); end
    @(negedge clk); #1;
    checks++; if (count !== 3'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL single_drain got %0d/%b exp 0/0", count, wr_en); end
    wr_ack = 1'b0;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); in_valid = 1'b1; in_idx = 4'(k); in_data = 32'(k * 17);
    end
    @(negedge clk); in_valid = 1'b1; in_idx = 4'd9; in_data = 32'h99; #1;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_count got %0d exp 4", count); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_ready got %b exp 0", in_ready); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (count !== 3'd4 || wr_idx !== 4'd1) begin errors++; $display("FAIL fill_reject got %0d/%h exp 4/1", count, wr_idx); end
    wr_ack = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      checks++; if (wr_idx !== 4'(k) || wr_data !== 32'(k * 17)) begin errors++; $display("FAIL fill_order%0d got %h/%h exp %h/%h", k, wr_idx, wr_data, 4'(k), 32'(k * 17)); end
      @(negedge clk); #1;
    end
    checks++; if (count !== 3'd0 || wr_en !== 1'b0) begin errors++; $display("FAIL fill_empty got %0d/%b exp 0/0", count, wr_en); end
    wr_ack = 1'b0;
  endtask

  task automatic test_forward();
    @(negedge clk); in_valid = 1'b1; in_idx = 4'd7; in_data = 32'hA;
    @(negedge clk); in_idx = 4'd7; in_data = 32'hB;
    @(negedge clk); in_idx = 4'd2; in_data = 32'hC;
    @(negedge clk); in_valid = 1'b0; rd_idx = 4'd7; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hB) begin errors++; $display("FAIL fwd_youngest got %b/%h exp 1/b", fwd_hit, fwd_data); end
    rd_idx = 4'd9; #1;
    checks++; if (fwd_hit !== 1'b0 || fwd_data !== 32'd0) begin errors++; $display("FAIL fwd_miss got %b/%h exp 0/0", fwd_hit, fwd_data); end
    rd_idx = 4'd2; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hC) begin errors++; $display("FAIL fwd_idx2 got %b/%h exp 1/c", fwd_hit, fwd_data); end
    in_valid = 1'b1; in_idx = 4'd3; in_data = 32'hD; rd_idx = 4'd3; #1;
    checks++; if (fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_enq_hidden got %b exp 0", fwd_hit); end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (fwd_hit !== 1'b1 || fwd_data !== 32'hD) begin errors++; $display("FAIL fwd_enq_visible got %b/%h exp 1/d", fwd_hit, fwd_data); end
    wr_ack = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++; if (count !== 3'd1 || fwd_hit !== 1'b1 || fwd_data !== 32'hD) begin errors++; $display("FAIL fwd_acked_head got %0d/%b/%h exp 1/1/d", count, fwd_hit, fwd_data); end
    @(negedge clk); #1;
    checks++; if (count !== 3'd0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL fwd_drained got %0d/%b exp 0/0", count, fwd_hit); end
    wr_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    @(negedge clk); in_valid = 1'b1; in_idx = 4'd8; in_data = 32'h100;
    @(negedge clk); in_data = 32'h101;
    for (int j = 0; j < 5; j++) begin
      @(negedge clk); #1;
      checks++; if (count !== 3'd2 || wr_data !== 32'(32'h100 + j)) begin errors++; $display("FAIL b2b_%0d got %0d/%h exp 2/%h", j, count, wr_data, 32'(32'h100 + j)); end
      in_data = 32'(32'h102 + j); in_valid = 1'b1; wr_ack = 1'b1;
    end
    @(negedge clk); in_valid = 1'b0; #1;
    checks++; if (count !== 3'd2 || wr_data !== 32'h105) begin errors++; $display("FAIL b2b_tail1 got %0d/%h exp 2/105", count, wr_data); end
    @(negedge clk); #1;
    checks++; if (wr_data !== 32'h106) begin errors++; $display("FAIL b2b_tail2 got %h exp 106", wr_data); end
    @(negedge clk); #1;
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL b2b_empty got %0d exp 0", count); end
    wr_ack = 1'b0;
  endtask

  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); in_valid = 1'b1; in_idx = 4'(k + 10); in_data = 32'(k);
    end
    @(negedge clk); flush = 1'b1; wr_ack = 1'b1; in_idx = 4'd6; #1;
    checks++; if (count !== 3'd3 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_pre got %0d/%b exp 3/0", count, in_ready); end
    @(negedge clk); flush = 1'b0; wr_ack = 1'b0; #1;
    checks++; if (count !== 3'd0 || wr_en !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL flush_state got %0d/%b/%b exp 0/0/0", count, wr_en, in_ready); end
    @(negedge clk); #1;
    checks++; if (count !== 3'd0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_resume got %0d/%b exp 0/1", count, in_ready); end
    in_valid = 1'b0;
  endtask

  task automatic test_rst_mid();
    @(negedge clk); in_valid = 1'b1; in_idx = 4'd4; in_data = 32'h44;
    @(negedge clk); in_idx = 4'd5;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0; in_valid = 1'b0; rd_idx = 4'd4; #1;
    checks++; if (count !== 3'd0 || wr_en !== 1'b0 || wr_data !== 32'd0) begin errors++; $display("FAIL rst_mid got %0d/%b/%h exp 0/0/0", count, wr_en, wr_data); end
    checks++; if (fwd_hit !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_fwd got %b/%b exp 0/1", fwd_hit, in_ready); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk); in_valid = 1'b1; in_idx = 4'd0; in_data = 32'h55; #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL zero_ready got %b exp 1", in_ready); end
    @(negedge clk); in_valid = 1'b0; rd_idx = 4'd0; #1;
`ifdef REGFILE_WB_ZERO_REG_EN
    checks++; if (count !== 3'd0 || fwd_hit !== 1'b0) begin errors++; $display("FAIL zero_dropped got %0d/%b exp 0/0", count, fwd_hit); end
`else
    checks++; if (count !== 3'd1 || fwd_hit !== 1'b1 || fwd_data !== 32'h55) begin errors++; $display("FAIL zero_normal got %0d/%b/%h exp 1/1/55", count, fwd_hit, fwd_data); end
`endif
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_forward();
    test_back_to_back();
    test_flush();
    test_rst_mid();
    test_zero_reg();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-back side of the 16x32 register file.
- Accepts write requests (destination index + data) from the execute stage over a valid/ready handshake.
- Buffers requests in an in-order queue and drains them one per accepted cycle into the register file write port.
- Provides combinational read-after-write forwarding, so a read of a register with a pending write returns the newest queued value.

Parameters:
- DEPTH, 4, queue entries; power of two, minimum 2.
- DW, 32, data width.
- AW, 4, register index width (16 registers).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  producer has a write request.
- in_ready  output  1  queue can accept this cycle.
- in_idx  input  AW  destination register index.
- in_data  input  DW  write data.
- flush  input  1  discard all queued requests.
- wr_en  output  1  head entry presented to register file.
- wr_idx  output  AW  head entry index.
- wr_data  output  DW  head entry data.
- wr_ack  input  1  register file consumed head this cycle.
- rd_idx  input  AW  index currently being read by the register file read port.
- fwd_hit  output  1  a queued write to rd_idx exists.
- fwd_data  output  DW  data of the youngest queued write to rd_idx.
- count  output  clog2(DEPTH)+1  number of occupied entries.

Behaviour:
- Reset (rst=1 at posedge): head pointer = 0, tail pointer = 0, count = 0, state = RUN. While count=0: wr_en=0, wr_idx=0, wr_data=0, fwd_hit=0, fwd_data=0. Storage contents are don't-care but must never be presented while invalid. rst mid-operation discards all entries and any in-flight handshake; rst overrides flush.
- Enqueue: in_valid & in_ready at posedge writes {in_idx, in_data} at tail; tail advances modulo DEPTH.
- in_ready = (count < DEPTH) & ~flush & (state == RUN). Purely combinational; no dependence on in_valid.
- Dequeue: wr_en & wr_ack at posedge advances head modulo DEPTH.
- wr_en = (count != 0). wr_idx/wr_data are show-ahead from head and must be 0 when wr_en=0.
- wr_ack while wr_en=0 is ignored.
- Latency: a request accepted at edge N appears on wr_* at edge N+1 when the queue was empty.
- Simultaneous enqueue and dequeue: count unchanged. This is legal when count=DEPTH only if in_ready were high; it is not, so no enqueue occurs when full.
- Full: count = DEPTH → in_ready=0; the head stays presented until acked.
- Empty: no underflow; count never wraps below 0.
- Forwarding:
  - Scan all occupied entries. fwd_hit=1 if any entry has idx == rd_idx.
  - fwd_data = data of the youngest (closest to tail) matching entry; 0 when no hit.
  - Entries in the register being enqueued this cycle are not visible until the next cycle.
  - The head entry being acked this cycle is still visible this cycle.
- State machine:
  - RUN: normal operation. flush=1 → FLUSH.
  - FLUSH: one cycle. Pointers and count cleared at the entering edge, so count=0 and in_ready=0 throughout FLUSH. Returns to RUN next edge unless flush is still 1.
  - flush and wr_ack in the same cycle: flush wins; the acked head is treated as dropped (the register file may still have written it, which is correct).
  - flush and in_valid in the same cycle: the request is not accepted (in_ready=0).
- Pointer width: clog2(DEPTH). count is tracked separately to distinguish full from empty.

Optional Feature:
- Macro: REGFILE_WB_ZERO_REG_EN.
- Defined: register 0 is hardwired to zero.
  - Requests with in_idx=0 are handshaken normally (in_ready unchanged) but not stored; count does not increment.
  - fwd_hit is forced to 0 when rd_idx=0.
- Undefined: index 0 is treated like any other register.

Test Plan:
- Reset then single write: in_idx=5, in_data=32'hDEAD_BEEF, wr_ack=1 held → wr_en=1 with wr_idx=5, wr_data=DEADBEEF one cycle after acceptance; count goes 1→0 the following edge.
- Fill to full with wr_ack=0: write idx 1..4 with data 32'h11..32'h44 → count=4, in_ready=0, a 5th in_valid is not accepted. Then ack four times → outputs 1/11, 2/22, 3/33, 4/44 in order, count=0, wr_en=0.
- Forwarding youngest-wins: queue idx 7 ← 32'hA, then idx 7 ← 32'hB, then idx 2 ← 32'hC with no ack; rd_idx=7 → fwd_hit=1, fwd_data=B. rd_idx=9 → fwd_hit=0, fwd_data=0.
- Simultaneous enqueue/dequeue at count=2 for 5 cycles → count stays 2 and data order is preserved.
- Flush with count=3, with in_valid and wr_ack also high → next cycle count=0, wr_en=0, in_ready=0 for the FLUSH cycle, 1 the cycle after. rst asserted mid-fill → identical cleared state.
- With REGFILE_WB_ZERO_REG_EN defined: write idx 0 ← 32'h55 → handshake completes, count stays 0, and rd_idx=0 gives fwd_hit=0. Without the macro: count=1 and fwd_hit=1, fwd_data=55.
